// File: rtl/shift_toggle_register.sv
// Multi-mode WIDTH-bit register built as T flip-flops: hold, shift, load, toggle, up/down count.
// Define SHIFT_TOGGLE_ROTATE_EN to make mode 111 rotate right; otherwise mode 111 holds.
module shift_toggle_register #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             si_r,
   input  logic             si_l,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             so_r,
   output logic             so_l,
   output logic             wrap
);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHR   = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_LOAD  = 3'b011;
   localparam logic [2:0] MODE_TOG   = 3'b100;
   localparam logic [2:0] MODE_UP    = 3'b101;
   localparam logic [2:0] MODE_DOWN  = 3'b110;
   localparam logic [2:0] MODE_ROT   = 3'b111;

   logic [WIDTH-1:0] q_reg;
   logic             wrap_reg;
   logic [WIDTH-1:0] t_next;
   logic             wrap_next;
   logic [WIDTH-1:0] shr_src;
   logic [WIDTH-1:0] shl_src;
   logic [WIDTH-1:0] rot_src;
   logic [WIDTH-1:0] ones_below;
   logic [WIDTH-1:0] zeros_below;

   assign shr_src = {si_r, q_reg[WIDTH-1:1]};
   assign shl_src = {q_reg[WIDTH-2:0], si_l};
`ifdef SHIFT_TOGGLE_ROTATE_EN
   assign rot_src = {q_reg[0], q_reg[WIDTH-1:1]};
`else
   assign rot_src = q_reg;
`endif

   // Synchronous T-enable chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
   always_comb begin
      logic acc_ones;
      logic acc_zeros;
      acc_ones    = 1'b1;
      acc_zeros   = 1'b1;
      ones_below  = '0;
      zeros_below = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones_below[i]  = acc_ones;
         zeros_below[i] = acc_zeros;
         acc_ones       = acc_ones & q_reg[i];
         acc_zeros      = acc_zeros & ~q_reg[i];
      end
   end

   function automatic logic t_bit(input logic [2:0] m, input logic qb, input logic shr_b,
                                  input logic shl_b, input logic d_b, input logic rot_b,
                                  input logic ones_b, input logic zeros_b);
      logic t;
      case (m)
         MODE_HOLD: t = 1'b0;
         MODE_SHR:  t = qb ^ shr_b;
         MODE_SHL:  t = qb ^ shl_b;
         MODE_LOAD: t = qb ^ d_b;
         MODE_TOG:  t = d_b;
         MODE_UP:   t = ones_b;
         MODE_DOWN: t = zeros_b;
         MODE_ROT:  t = qb ^ rot_b;
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_tbit
         assign t_next[gi] = en & t_bit(mode, q_reg[gi], shr_src[gi], shl_src[gi], d[gi],
                                        rot_src[gi], ones_below[gi], zeros_below[gi]);
      end
   endgenerate

   assign wrap_next = en & (((mode == MODE_UP) & (&q_reg)) | ((mode == MODE_DOWN) & ~(|q_reg)));

   always_ff @(negedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg    <= '0;
         wrap_reg <= 1'b0;
      end else begin
         q_reg    <= q_reg ^ t_next;
         wrap_reg <= wrap_next;
      end
   end

   assign q    = q_reg;
   assign wrap = wrap_reg;
   assign so_r = q_reg[0];
   assign so_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_shift_toggle_register.sv
// Directed-vector bench for shift_toggle_register at WIDTH=8; updates happen on the falling edge.
module tb_shift_toggle_register;

   logic       Clk;
   logic       reset_n;
   logic       en;
   logic [2:0] mode;
   logic       si_r;
   logic       si_l;
   logic [7:0] d;
   logic [7:0] q;
   logic       so_r;
   logic       so_l;
   logic       wrap;

   int n_vec;
   int n_err;

   shift_toggle_register #(.WIDTH(8)) dut (
      .Clk     (Clk),
      .reset_n (reset_n),
      .en      (en),
      .mode    (mode),
      .si_r    (si_r),
      .si_l    (si_l),
      .d       (d),
      .q       (q),
      .so_r    (so_r),
      .so_l    (so_l),
      .wrap    (wrap)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Drive inputs between edges, let one falling edge act, then sample after the next rising edge.
   task automatic apply(input logic e, input logic [2:0] m, input logic [7:0] dv,
                        input logic sr, input logic sl);
      en   = e;
      mode = m;
      d    = dv;
      si_r = sr;
      si_l = sl;
      @(negedge Clk);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      en      = 1'b0;
      mode    = 3'b000;
      si_r    = 1'b0;
      si_l    = 1'b0;
      d       = 8'h00;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_q", {24'h0, q}, 32'h00);
      check("reset_wrap", {31'h0, wrap}, 32'h0);
      reset_n = 1'b1;

      // Asynchronous reset mid-count
      apply(1'b1, 3'b011, 8'h5A, 1'b0, 1'b0);
      check("load_5a", {24'h0, q}, 32'h5A);
      mode = 3'b101;
      reset_n = 1'b0;
      #1;
      check("async_rst_q", {24'h0, q}, 32'h00);
      check("async_rst_wrap", {31'h0, wrap}, 32'h0);
      #1;
      reset_n = 1'b1;
      apply(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      check("post_rst_up", {24'h0, q}, 32'h01);

      // Load and shift
      apply(1'b1, 3'b011, 8'hB4, 1'b0, 1'b0);
      check("load_b4", {24'h0, q}, 32'hB4);
      check("so_r_b4", {31'h0, so_r}, 32'h0);
      apply(1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
      check("shr1", {24'h0, q}, 32'hDA);
      apply(1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
      check("shr2", {24'h0, q}, 32'hED);
      check("so_r_ed", {31'h0, so_r}, 32'h1);
      apply(1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
      check("shr3", {24'h0, q}, 32'hF6);
      check("so_l_pre1", {31'h0, so_l}, 32'h1);
      apply(1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
      check("shl1", {24'h0, q}, 32'hEC);
      check("so_l_pre2", {31'h0, so_l}, 32'h1);
      apply(1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
      check("shl2", {24'h0, q}, 32'hD8);
      check("shift_wrap", {31'h0, wrap}, 32'h0);

      // Toggle and enable
      apply(1'b1, 3'b011, 8'h0F, 1'b0, 1'b0);
      apply(1'b1, 3'b100, 8'hFF, 1'b0, 1'b0);
      check("toggle_ff", {24'h0, q}, 32'hF0);
      apply(1'b0, 3'b100, 8'hFF, 1'b0, 1'b0);
      check("toggle_en0", {24'h0, q}, 32'hF0);
      apply(1'b1, 3'b100, 8'h3C, 1'b0, 1'b0);
      check("toggle_3c", {24'h0, q}, 32'hCC);

      // Up wrap
      apply(1'b1, 3'b011, 8'hFE, 1'b0, 1'b0);
      apply(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      check("up_ff", {24'h0, q}, 32'hFF);
      check("up_ff_wrap", {31'h0, wrap}, 32'h0);
      apply(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      check("up_00", {24'h0, q}, 32'h00);
      check("up_00_wrap", {31'h0, wrap}, 32'h1);
      apply(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      check("up_01", {24'h0, q}, 32'h01);
      check("up_01_wrap", {31'h0, wrap}, 32'h0);
      apply(1'b1, 3'b011, 8'h0F, 1'b0, 1'b0);
      apply(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      check("up_carry", {24'h0, q}, 32'h10);

      // Down wrap and mode switch
      apply(1'b1, 3'b011, 8'h01, 1'b0, 1'b0);
      apply(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      check("dn_00", {24'h0, q}, 32'h00);
      check("dn_00_wrap", {31'h0, wrap}, 32'h0);
      apply(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      check("dn_ff", {24'h0, q}, 32'hFF);
      check("dn_ff_wrap", {31'h0, wrap}, 32'h1);
      apply(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
      check("hold_ff", {24'h0, q}, 32'hFF);
      check("hold_wrap", {31'h0, wrap}, 32'h0);
      apply(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      check("dn_fe", {24'h0, q}, 32'hFE);
      apply(1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
      apply(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      check("dn2_wrap", {31'h0, wrap}, 32'h1);
      apply(1'b0, 3'b110, 8'h00, 1'b0, 1'b0);
      check("en0_q", {24'h0, q}, 32'hFF);
      check("en0_wrap", {31'h0, wrap}, 32'h0);

      // Rotate / mode 111
      apply(1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
      apply(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
`ifdef SHIFT_TOGGLE_ROTATE_EN
      check("mode111", {24'h0, q}, 32'hC0);
`else
      check("mode111", {24'h0, q}, 32'h81);
`endif
      check("mode111_wrap", {31'h0, wrap}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
